// File: rtl/trdb_packet_scheduler.sv
// trdb_packet_scheduler
// Queues packet requests from the packet-type selection logic and drains them
// to the packet emitter over a valid/ready handshake.  On overflow, requests
// are dropped until the queue has drained.  A format 3 / subformat 3 packet
// with qual_status TRACE_LOST is then emitted before normal queuing resumes.
// Also owns the resync counter and its max/one-before-max indications.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_*_i                       packet request (no back-pressure)
//   resync_rst_i/resync_cnt_en_i  resync counter clear / count enable
//   valid_o, ready_i              head packet handshake to the emitter
//   format_o .. qual_status_o     head packet fields (registered)
//   packets_lost_o                high while dropping or injecting TRACE_LOST
//   level_o                       FIFO occupancy
//   gt_max_resync_o               counter >= RESYNC_MAX
//   et_max_resync_o               counter == RESYNC_MAX-1

package trdb_pkg;
    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'd0,
        F_DIFF_DELTA = 2'd1,
        F_ADDR_ONLY  = 2'd2,
        F_SYNC       = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'd0,
        SF_TRAP    = 2'd1,
        SF_CONTEXT = 2'd2,
        SF_SUPPORT = 2'd3
    } trdb_f_sync_subformat_e;

    typedef enum logic [1:0] {
        NO_CHANGE  = 2'd0,
        ENDED_REP  = 2'd1,
        TRACE_LOST = 2'd2,
        ENDED_NTR  = 2'd3
    } qual_status_e;

    typedef struct packed {
        trdb_format_e           format;
        trdb_f_sync_subformat_e subformat;
        logic                   thaddr;
        logic                   cause_mux;
        logic                   tval_mux;
        qual_status_e           qual_status;
    } trdb_pkt_t;
endpackage

module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int RESYNC_MAX = 16,
    parameter int CNT_W      = $clog2(RESYNC_MAX) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    input  trdb_format_e           req_format_i,
    input  trdb_f_sync_subformat_e req_subformat_i,
    input  logic                   req_thaddr_i,
    input  logic                   req_cause_mux_i,
    input  logic                   req_tval_mux_i,
    input  qual_status_e           req_qual_status_i,
    input  logic                   resync_rst_i,
    input  logic                   resync_cnt_en_i,
    output logic                   valid_o,
    input  logic                   ready_i,
    output trdb_format_e           format_o,
    output trdb_f_sync_subformat_e subformat_o,
    output logic                   thaddr_o,
    output logic                   cause_mux_o,
    output logic                   tval_mux_o,
    output qual_status_e           qual_status_o,
    output logic                   packets_lost_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   gt_max_resync_o,
    output logic                   et_max_resync_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_LOST   = 2'd1,
        ST_INJECT = 2'd2
    } state_e;

    localparam trdb_pkt_t INJECT_PKT = '{format: F_SYNC, subformat: SF_SUPPORT,
        thaddr: 1'b0, cause_mux: 1'b0, tval_mux: 1'b0, qual_status: TRACE_LOST};
    localparam trdb_pkt_t IDLE_PKT = '{format: F_OPT_EXT, subformat: SF_START,
        thaddr: 1'b0, cause_mux: 1'b0, tval_mux: 1'b0, qual_status: NO_CHANGE};

    trdb_pkt_t        mem_q [DEPTH];
    trdb_pkt_t        mem_d [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    trdb_pkt_t        head_q, head_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gt_q, gt_d, et_q, et_d;

    logic             pop_s, fifo_pop_s, push_s, full_s;
    trdb_pkt_t        req_pkt_s;

    // Next-state computation for FIFO, state machine, output register and resync counter
    always_comb begin
        req_pkt_s = '{format: req_format_i, subformat: req_subformat_i,
                      thaddr: req_thaddr_i, cause_mux: req_cause_mux_i,
                      tval_mux: req_tval_mux_i, qual_status: req_qual_status_i};

        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;

        pop_s      = valid_q && ready_i;
        // in INJECT the head is the synthetic packet, not a FIFO entry
        fifo_pop_s = pop_s && (state_q != ST_INJECT);
        full_s     = (count_q == LW'(DEPTH));
        // a full FIFO still accepts when its head leaves in the same cycle
        push_s     = (state_q == ST_NORMAL) && req_valid_i && (!full_s || fifo_pop_s);

        if (push_s) begin
            mem_d[wptr_q] = req_pkt_s;
            wptr_d        = wptr_q + AW'(1);
        end else begin
            wptr_d = wptr_q;
        end

        if (fifo_pop_s) begin
            rptr_d = rptr_q + AW'(1);
        end else begin
            rptr_d = rptr_q;
        end

        case ({push_s, fifo_pop_s})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_NORMAL: begin
                if (req_valid_i && !push_s) begin
                    state_d = ST_LOST;
                end else begin
                    state_d = ST_NORMAL;
                end
            end
            ST_LOST: begin
                // move on once nothing remains to be presented after this cycle
                if (count_d == {LW{1'b0}}) begin
                    state_d = ST_INJECT;
                end else begin
                    state_d = ST_LOST;
                end
            end
            ST_INJECT: begin
                if (pop_s) begin
                    state_d = ST_NORMAL;
                end else begin
                    state_d = ST_INJECT;
                end
            end
            default: state_d = ST_NORMAL;
        endcase

        // output register shows the head of the next-cycle queue
        valid_d = (state_d == ST_INJECT) || (count_d != {LW{1'b0}});
        if (state_d == ST_INJECT) begin
            head_d = INJECT_PKT;
        end else if (count_d != {LW{1'b0}}) begin
            head_d = mem_d[rptr_d];
        end else begin
            head_d = IDLE_PKT;
        end
        lost_d = (state_d != ST_NORMAL);

        if (resync_rst_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (resync_cnt_en_i && (cnt_q < CNT_W'(RESYNC_MAX))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        gt_d = (cnt_d >= CNT_W'(RESYNC_MAX));
        et_d = (cnt_d == CNT_W'(RESYNC_MAX - 1));
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= IDLE_PKT;
            end
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {LW{1'b0}};
            state_q <= ST_NORMAL;
            valid_q <= 1'b0;
            head_q  <= IDLE_PKT;
            lost_q  <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            gt_q    <= 1'b0;
            et_q    <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            state_q <= state_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            lost_q  <= lost_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            et_q    <= et_d;
        end
    end

    assign valid_o         = valid_q;
    assign format_o        = head_q.format;
    assign subformat_o     = head_q.subformat;
    assign thaddr_o        = head_q.thaddr;
    assign cause_mux_o     = head_q.cause_mux;
    assign tval_mux_o      = head_q.tval_mux;
    assign qual_status_o   = head_q.qual_status;
    assign packets_lost_o  = lost_q;
    assign level_o         = count_q;
    assign gt_max_resync_o = gt_q;
    assign et_max_resync_o = et_q;
endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Self-checking bench for trdb_packet_scheduler: a queue-based reference model
// fed by directed and random stimulus, with a negedge monitor comparing the
// DUT against a scoreboard of expected packets.
module tb_trdb_packet_scheduler;
    import trdb_pkg::*;

    localparam int DEPTH = 4;
    localparam int RMAX  = 16;
    localparam int CW    = $clog2(RMAX) + 1;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic req_valid = 1'b0;
    trdb_pkt_t req_pkt = '0;
    logic resync_rst = 1'b0;
    logic resync_en = 1'b0;
    logic ready = 1'b0;

    logic                   valid_o;
    trdb_format_e           format_o;
    trdb_f_sync_subformat_e subformat_o;
    logic                   thaddr_o, cause_mux_o, tval_mux_o;
    qual_status_e           qual_status_o;
    logic                   packets_lost_o;
    logic [$clog2(DEPTH):0] level_o;
    logic                   gt_o, et_o;

    localparam trdb_pkt_t LOST_PKT = '{format: F_SYNC, subformat: SF_SUPPORT,
        thaddr: 1'b0, cause_mux: 1'b0, tval_mux: 1'b0, qual_status: TRACE_LOST};

    trdb_packet_scheduler #(.DEPTH(DEPTH), .RESYNC_MAX(RMAX), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid),
        .req_format_i(req_pkt.format), .req_subformat_i(req_pkt.subformat),
        .req_thaddr_i(req_pkt.thaddr), .req_cause_mux_i(req_pkt.cause_mux),
        .req_tval_mux_i(req_pkt.tval_mux), .req_qual_status_i(req_pkt.qual_status),
        .resync_rst_i(resync_rst), .resync_cnt_en_i(resync_en),
        .valid_o(valid_o), .ready_i(ready),
        .format_o(format_o), .subformat_o(subformat_o), .thaddr_o(thaddr_o),
        .cause_mux_o(cause_mux_o), .tval_mux_o(tval_mux_o), .qual_status_o(qual_status_o),
        .packets_lost_o(packets_lost_o), .level_o(level_o),
        .gt_max_resync_o(gt_o), .et_max_resync_o(et_o)
    );

    always #5 clk = ~clk;

    // reference model state
    trdb_pkt_t exp_q[$];
    trdb_pkt_t m_fifo[$];
    bit m_lost = 1'b0;
    bit m_inject = 1'b0;
    int m_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
        end
    endtask

    function automatic bit m_valid();
        return (m_fifo.size() > 0) || m_inject;
    endfunction

    function automatic trdb_pkt_t rand_pkt();
        return trdb_pkt_t'(9'($urandom()));
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        exp_q.delete();
        m_lost = 1'b0;
        m_inject = 1'b0;
        m_cnt = 0;
    endtask

    // One clock edge of the behavioural model, using the inputs the DUT samples
    task automatic model_step();
        bit pop, full, pre_lost, pre_inj;
        if (resync_rst) m_cnt = 0;
        else if (resync_en && m_cnt < RMAX) m_cnt++;
        pop      = m_valid() && ready;
        full     = (m_fifo.size() == DEPTH);
        pre_lost = m_lost;
        pre_inj  = m_inject;
        if (pop) begin
            if (pre_inj) begin
                m_inject = 1'b0;
                m_lost   = 1'b0;
            end else begin
                void'(m_fifo.pop_front());
            end
        end
        if (req_valid && !pre_lost) begin
            if (!full || pop) begin
                m_fifo.push_back(req_pkt);
                exp_q.push_back(req_pkt);
            end else begin
                m_lost = 1'b1;
                exp_q.push_back(LOST_PKT);
            end
        end
        if (m_lost && !m_inject && m_fifo.size() == 0) m_inject = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input bit v, input trdb_pkt_t p);
        req_valid = v;
        req_pkt = p;
    endtask

    task automatic chk_reset();
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_lost", packets_lost_o, 0);
        chk("rst_fields", {format_o, subformat_o, thaddr_o, cause_mux_o, tval_mux_o, qual_status_o}, 0);
        chk("rst_gt", gt_o, 0);
        chk("rst_et", et_o, 0);
    endtask

    // Monitor: compare outputs with the model and the scoreboard head
    trdb_pkt_t mon_exp;
    always @(negedge clk) begin
        if (rst_ni) begin
            chk("valid", valid_o, m_valid());
            chk("level", level_o, m_fifo.size());
            chk("lost", packets_lost_o, m_lost);
            chk("gt", gt_o, m_cnt >= RMAX);
            chk("et", et_o, m_cnt == RMAX - 1);
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pkt", 1, 0);
                end else begin
                    mon_exp = exp_q[0];
                    chk("pkt", {format_o, subformat_o, thaddr_o, cause_mux_o, tval_mux_o, qual_status_o},
                        32'(mon_exp));
                    if (ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        trdb_pkt_t p;
        int guard;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_reset();
        rst_ni = 1'b1;

        // single request: F_SYNC/SF_TRAP/thaddr=1/cause_mux=0
        p = '{format: F_SYNC, subformat: SF_TRAP, thaddr: 1'b1, cause_mux: 1'b0,
              tval_mux: 1'b0, qual_status: NO_CHANGE};
        ready = 1'b1;
        set_req(1'b1, p);
        step();
        chk("single_valid", valid_o, 1);
        chk("single_level", level_o, 1);
        set_req(1'b0, p);
        step();
        chk("single_drained", level_o, 0);
        step();

        // back-pressure: fill to DEPTH then drain in order
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1, rand_pkt());
            step();
        end
        set_req(1'b0, '0);
        step();
        chk("bp_level", level_o, DEPTH);
        chk("bp_nolost", packets_lost_o, 0);
        ready = 1'b1;
        repeat (6) step();

        // overflow: fifth request dropped, later LOST requests dropped too
        ready = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) begin
            set_req(1'b1, rand_pkt());
            step();
        end
        chk("ovf_lost", packets_lost_o, 1);
        chk("ovf_level", level_o, DEPTH);
        set_req(1'b0, '0);
        ready = 1'b1;
        repeat (10) step();
        chk("ovf_recovered", packets_lost_o, 0);

        // full + simultaneous push/pop
        ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_req(1'b1, rand_pkt());
            step();
        end
        ready = 1'b1;
        set_req(1'b1, rand_pkt());
        step();
        chk("fullpp_level", level_o, DEPTH);
        chk("fullpp_nolost", packets_lost_o, 0);
        set_req(1'b0, '0);
        repeat (8) step();

        // resync counter
        resync_en = 1'b1;
        repeat (RMAX - 1) step();
        chk("rs_et15", et_o, 1);
        chk("rs_gt15", gt_o, 0);
        step();
        chk("rs_gt16", gt_o, 1);
        chk("rs_et16", et_o, 0);
        repeat (3) step();
        chk("rs_sat", gt_o, 1);
        resync_rst = 1'b1;
        step();
        chk("rs_clr_gt", gt_o, 0);
        chk("rs_clr_et", et_o, 0);
        resync_rst = 1'b0;
        resync_en = 1'b0;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            set_req($urandom_range(0, 99) < 55, rand_pkt());
            ready      = ($urandom_range(0, 99) < 60);
            resync_rst = ($urandom_range(0, 99) < 4);
            resync_en  = ($urandom_range(0, 99) < 40);
            step();
        end
        set_req(1'b0, '0);
        resync_rst = 1'b0;
        resync_en = 1'b0;
        ready = 1'b1;
        repeat (DEPTH + 4) step();

        // reset mid-drain in LOST with level 3
        ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_req(1'b1, rand_pkt());
            step();
        end
        set_req(1'b0, '0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        chk("mid_level3", level_o, 3);
        chk("mid_lost", packets_lost_o, 1);
        #2 rst_ni = 1'b0;
        model_reset();
        #1 chk_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        p = '{format: F_ADDR_ONLY, subformat: SF_CONTEXT, thaddr: 1'b1, cause_mux: 1'b1,
              tval_mux: 1'b1, qual_status: ENDED_REP};
        ready = 1'b1;
        set_req(1'b1, p);
        step();
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_fmt", format_o, F_ADDR_ONLY);
        set_req(1'b0, '0);
        step();

        // bounded final drain
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        chk("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
